// File: rtl/rr_sel4_if.sv
// rtl/rr_sel4_if.sv - request/grant/handshake bundle between requesters, rr_sel4 and the downstream stage
`timescale 1ns/1ps

interface rr_sel4_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       req;
    logic             out_ready;
    logic [1:0]       sel;
    logic [3:0]       gnt;
    logic             out_valid;
    logic [3:0]       done;
    logic [CNT_W-1:0] xfer_cnt;

    modport master (
        input  req, out_ready,
        output sel, gnt, out_valid, done, xfer_cnt
    );

    modport slave (
        output req, out_ready,
        input  sel, gnt, out_valid, done, xfer_cnt
    );
endinterface

// File: rtl/rr_sel4.sv
// rtl/rr_sel4.sv - round-robin select sequencer driving a 4-to-1 mux select with a valid/ready output handshake
`timescale 1ns/1ps

module rr_sel4 #(
    parameter int CNT_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    rr_sel4_if.master bus
);
    typedef enum logic {IDLE, GRANT} stateT;

    stateT            state;
    logic [1:0]       ptr;
    logic [1:0]       selReg;
    logic [3:0]       gntReg;
    logic             outValid;
    logic [CNT_W-1:0] cnt;

    logic             pickValid;
    logic [1:0]       pickIdx;
    logic [1:0]       scanIdx;

    // Scan from the farthest slot back to ptr so the nearest requester wins.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = ptr;
        scanIdx   = ptr;
        for (int k = 3; k >= 0; k--) begin
            scanIdx = ptr + 2'(k);
            if (bus.req[scanIdx]) begin
                pickValid = 1'b1;
                pickIdx   = scanIdx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            selReg   <= 2'd0;
            gntReg   <= 4'd0;
            outValid <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pickValid) begin
                        selReg   <= pickIdx;
                        gntReg   <= 4'b0001 << pickIdx;
                        outValid <= 1'b1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // Grant is frozen until the consumer takes it; req is ignored here.
                    if (bus.out_ready) begin
                        state    <= IDLE;
                        outValid <= 1'b0;
                        gntReg   <= 4'd0;
                        ptr      <= selReg + 2'd1;
                        cnt      <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.sel       = selReg;
    assign bus.gnt       = gntReg;
    assign bus.out_valid = outValid;
    assign bus.done      = gntReg & {4{outValid & bus.out_ready}};
    assign bus.xfer_cnt  = cnt;
endmodule

// File: doc/rr_sel4.md
# rr_sel4

Round-robin select sequencer that sits directly upstream of the processor's 4-to-1 datapath mux and drives its 2-bit select. Four requesters each present their operand on one mux input and raise a request. The block grants one requester at a time, holds the registered select stable for the whole transfer, and runs a valid/ready handshake with the stage that consumes the mux output. It also keeps a wrap-around count of completed transfers.

## Interface
- CNT_W, 8, width of transfer counter
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- req  input  4  request per mux input (bit 0 = inA … bit 3 = inD)
- out_ready  input  1  downstream accepts mux output this cycle
- sel  output  2  select to the 4-to-1 mux, registered
- gnt  output  4  one-hot grant, registered, held for whole transfer
- out_valid  output  1  mux output is valid for the granted requester
- done  output  4  combinational, gnt & {4{out_ready}} while out_valid; one-cycle completion strobe to requesters
- xfer_cnt  output  CNT_W  completed transfers, wraps

## Operation
- Internal state: FSM {IDLE, GRANT} and a 2-bit round-robin pointer ptr (highest priority index).
- Reset (rst=1 at an edge): state=IDLE, ptr=0, sel=0, gnt=0, out_valid=0, xfer_cnt=0. done is 0 because out_valid=0.
- IDLE:
  - out_valid=0, gnt=0, done=0.
  - If req==0: stay in IDLE.
  - Otherwise pick the first set bit scanning indices ptr, ptr+1, ptr+2, ptr+3 mod 4.
  - Next edge: sel=index, gnt=one-hot(index), out_valid=1, state=GRANT.
- GRANT:
  - sel and gnt are frozen. Changes on req are ignored, including the granted requester dropping req. The grant stands until transfer.
  - Transfer happens when out_valid & out_ready are high in the same cycle. done pulses for the granted bit in that cycle.
  - Next edge after a transfer: state=IDLE, out_valid=0, gnt=0, ptr=sel+1 mod 4 (3 wraps to 0), xfer_cnt=xfer_cnt+1 mod 2^CNT_W.
  - sel keeps its last value in IDLE.
  - If out_ready=0, hold everything indefinitely.
- Requester contract: a requester keeps req high until it sees its done bit, then deasserts req at the next edge.
- Fairness:
  - Only a completed transfer advances ptr.
  - With all four requesting continuously, the grant order is 0,1,2,3,0,… starting from ptr.
  - A requester is never granted twice while another requester waits.

## Timing
- Latency from req rising (sampled in IDLE, cycle N) to out_valid=1: one edge, so out_valid is high in cycle N+1.
- sel is valid in the same cycle as out_valid. The mux is combinational, so mux output is valid in that cycle too.
- Handshake completes in the first cycle with out_ready=1 while in GRANT. done is asserted in that same cycle with zero added latency.
- After a transfer, at least one IDLE cycle follows, during which arbitration uses the updated req. Peak throughput is one transfer per 2 cycles.
- Simultaneous rst and a transfer in the same cycle: reset wins. Counter and ptr go to 0 and there is no increment.
- Reset asserted mid-GRANT: at the next edge the grant is dropped with no completion recorded.
- Counter overflow: all-ones + 1 → 0, with no flag.
- req bits must be synchronous to clk. The block has no internal synchronizers.

## Test plan
- Reset mid-operation:
  - Stimulus: reset, then req=4'b0100, out_ready=1, with rst pulsed the cycle after out_valid rises.
  - Required: next cycle has out_valid=0, gnt=0, xfer_cnt=0.
  - After release, arbitration restarts with ptr=0 and sel=2 one cycle later.
- Round-robin order:
  - Stimulus: req=4'b1111 held, requesters dropping on done then re-raising, out_ready=1.
  - Required: sel sequence 0,1,2,3,0 on successive grants, transfers every 2 cycles, xfer_cnt=5 after 5 grants.
- Pointer wrap with skip:
  - Stimulus: after a transfer on index 3 (ptr=0), req=4'b0110.
  - Required: sel=1, gnt=4'b0010. After done, the next grant is sel=2.
- Backpressure:
  - Stimulus: req=4'b0001, out_ready=0 for 5 cycles, then 1; req=4'b1000 raised during the stall.
  - Required: sel=0 and gnt=4'b0001 stable for all stall cycles, done=0001 only in the ready cycle, then grant moves to index 3.
- Counter wrap:
  - Stimulus: CNT_W=2, 5 transfers.
  - Required: xfer_cnt goes 1,2,3,0,1.
- Idle hold:
  - Stimulus: req=0 for 10 cycles after reset.
  - Required: out_valid=0, gnt=0, done=0, sel=0 throughout.
